param_moore_detector: RTL and testbench
=======================================

Name: param_moore_detector

Overview:
Parametrised Moore-style serial sequence detector, successor to the fixed-pattern detector. Samples one bit per clock when qualified by in_valid. Matches it against a runtime-loadable PAT_LEN-bit pattern, in overlapping or non-overlapping mode. Provides a registered state-based detect flag and a saturating match counter, for bit-stream front ends in the RTL exercise suite.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
DEFAULT_PAT, 4'b1011, pattern active after reset; width PAT_LEN; MSB = first bit in time.
CNT_W, 8, width of match counter; legal range 2..16.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  qualifies in_bit for this cycle.
in_bit  input  1  serial data bit.
cfg_load  input  1  one-cycle strobe; loads cfg_pattern/cfg_overlap and restarts detection.
cfg_pattern  input  PAT_LEN  new pattern; MSB is the first bit in time.
cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
detected  output  1  Moore output; high while the FSM is in MATCH state.
match_count  output  CNT_W  number of matches since reset/cfg_load; saturates.

Behaviour:
- Reset (async assert, sync to clk edge on release):
  - hist=0, fill=0, detected=0, match_count=0.
  - pattern_q=DEFAULT_PAT, overlap_q=1.
- State:
  - hist: PAT_LEN-bit shift register; hist[0] is the newest bit.
  - fill: 0..PAT_LEN count of valid bits held, saturating at PAT_LEN.
  - FSM: IDLE (fill=0), FILLING (0<fill<PAT_LEN, no match), ARMED (fill=PAT_LEN, no match), MATCH.
  - detected = (state==MATCH). It is a registered state decode, never combinational from in_bit.
- Valid cycle (in_valid=1, cfg_load=0):
  - hist_n={hist[PAT_LEN-2:0],in_bit}; fill_n=min(fill+1,PAT_LEN).
  - Match is declared if fill_n==PAT_LEN and hist_n==pattern_q.
  - On match: next state MATCH; match_count += 1 unless already all-ones.
  - Overlap mode: after a match, fill stays PAT_LEN, so the next bit can complete another match.
  - Non-overlap mode: after a match, fill and hist clear in the same edge that enters MATCH. A new match then needs PAT_LEN fresh bits.
  - Otherwise, next state is FILLING or ARMED per fill_n.
- Latency: detected rises on the clk edge that samples the final pattern bit, and is visible one cycle after that bit is presented.
- Idle cycle (in_valid=0): all state holds, including detected. MATCH persists across gaps and leaves on the next valid bit that does not complete a match.
- Consecutive overlapping matches: detected stays high, and match_count increments on each such valid cycle.
- cfg_load (priority over in_valid):
  - Loads pattern_q=cfg_pattern and overlap_q=cfg_overlap.
  - Clears hist, fill, detected and match_count.
  - Any in_bit in that cycle is dropped.
  - New config takes effect from the next valid bit.
- Counter saturation: at 2^CNT_W-1, further matches still assert detected, but the count holds.
- Reset mid-operation: immediate return to the reset values above. A loaded pattern is lost and DEFAULT_PAT is restored.
- Pattern all-zeros is legal. The initial zero hist must not match until fill reaches PAT_LEN.

Decomposition:
- Shared package: FSM state enum (IDLE, FILLING, ARMED, MATCH), default-pattern constant, and legal-range constants for PAT_LEN/CNT_W. Include elaboration-time checks.
- One sub-module: sat_counter (params W; ports clk, rst, clr, inc, q) for match_count.
- The FSM, shift register and compare stay in the top.

Test Plan:
1. Default config (1011, overlap), valid stream 1,0,1,1,0,1,1 -> detected high after the 4th and 7th bits, low after 5th–6th; match_count=2.
2. cfg_load pattern 1011, overlap=0; same stream -> one match after the 4th bit; the tail 0,1,1 is too short; match_count=1; detected low after the 5th bit.
3. Stream 1,0,1 then in_valid=0 for 3 cycles, then 1 -> detected stays 0 during the gap, rises after the final 1, and holds through a subsequent 2-cycle gap.
4. PAT_LEN=2, CNT_W=2, cfg_load pattern 11, overlap=1; six valid 1s -> detected high from the 2nd bit onward; match_count goes 1,2,3 and holds at 3.
5. All-zeros pattern 0000 after reset; first three valid 0s -> no detect; fourth 0 -> detected=1, count=1.
6. cfg_load coincident with in_valid=1 while in MATCH -> detected=0, count=0, that in_bit ignored. Then assert rst mid-stream -> all outputs 0 immediately, and DEFAULT_PAT 1011 is active again.

Source files
------------

// File: rtl/param_moore_detector_pkg.sv
// Shared definitions for the parametrised Moore sequence detector:
// FSM states, reset pattern and legal parameter ranges.
package param_moore_detector_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILLING = 2'd1,
      ARMED   = 2'd2,
      MATCH   = 2'd3
   } state_t;

   localparam logic [3:0] DEFAULT_PAT_C = 4'b1011;

   localparam int PAT_LEN_MIN = 2;
   localparam int PAT_LEN_MAX = 16;
   localparam int CNT_W_MIN   = 2;
   localparam int CNT_W_MAX   = 16;

   function automatic bit in_range(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/param_moore_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/param_moore_detector.sv
// Serial Moore detector: matches the last PAT_LEN valid bits against a
// runtime-loadable pattern, with overlapping or non-overlapping matches.
module param_moore_detector
   import param_moore_detector_pkg::*;
#(
   parameter int                 PAT_LEN     = 4,
   parameter logic [PAT_LEN-1:0] DEFAULT_PAT = PAT_LEN'(DEFAULT_PAT_C),
   parameter int                 CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               cfg_load,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   input  logic               cfg_overlap,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output state_t             o_dbg_state
);

   if (!in_range(PAT_LEN, PAT_LEN_MIN, PAT_LEN_MAX)) begin : g_bad_pat_len
      $error("param_moore_detector: PAT_LEN %0d out of range", PAT_LEN);
   end
   if (!in_range(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_cnt_w
      $error("param_moore_detector: CNT_W %0d out of range", CNT_W);
   end

   localparam int                FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

   // Only PAT_LEN-1 older bits are kept; the oldest bit of a window exists
   // only in the combinational shift result used for the compare.
   state_t              r_state;
   state_t              w_state_n;
   logic [PAT_LEN-2:0]  r_hist;
   logic [PAT_LEN-2:0]  w_hist_n;
   logic [FILL_W-1:0]   r_fill;
   logic [FILL_W-1:0]   w_fill_n;
   logic [FILL_W-1:0]   w_fill_inc;
   logic [PAT_LEN-1:0]  w_shift;
   logic [PAT_LEN-1:0]  r_pattern;
   logic                r_overlap;
   logic                w_match;
   logic                w_inc;

   assign w_shift    = {r_hist, in_bit};
   assign w_fill_inc = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
   assign w_match    = (w_fill_inc == FILL_FULL) && (w_shift == r_pattern);
   assign w_inc      = in_valid && !cfg_load && w_match;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_hist    <= '0;
         r_fill    <= '0;
         r_pattern <= DEFAULT_PAT;
         r_overlap <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_hist  <= w_hist_n;
         r_fill  <= w_fill_n;
         if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_overlap <= cfg_overlap;
         end
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_hist_n  = r_hist;
      w_fill_n  = r_fill;
      if (cfg_load) begin
         w_state_n = IDLE;
         w_hist_n  = '0;
         w_fill_n  = '0;
      end else if (in_valid) begin
         if (w_match) begin
            w_state_n = MATCH;
            if (r_overlap) begin
               w_hist_n = w_shift[PAT_LEN-2:0];
               w_fill_n = FILL_FULL;
            end else begin
               w_hist_n = '0;
               w_fill_n = '0;
            end
         end else begin
            w_hist_n  = w_shift[PAT_LEN-2:0];
            w_fill_n  = w_fill_inc;
            w_state_n = (w_fill_inc == FILL_FULL) ? ARMED : FILLING;
         end
      end
   end

   assign detected    = (r_state == MATCH);
   assign o_dbg_state = r_state;

   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cfg_load),
      .inc (w_inc),
      .q   (match_count)
   );

endmodule

// File: tb/tb_param_moore_detector.sv
// Bench for param_moore_detector: hand-derived vector table, corner-case
// sequences, a PAT_LEN=2/CNT_W=2 instance, and a randomized queue-model phase.
module tb_param_moore_detector;
   import param_moore_detector_pkg::*;

   localparam int PL = 4;
   localparam int CW = 8;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main instance (defaults)
   logic          in_valid, in_bit, cfg_load, cfg_overlap;
   logic [PL-1:0] cfg_pattern;
   logic          detected;
   logic [CW-1:0] match_count;
   state_t        dbg_state;

   // small instance: PAT_LEN=2, CNT_W=2
   logic       b_in_valid, b_in_bit, b_cfg_load, b_cfg_overlap;
   logic [1:0] b_cfg_pattern;
   logic       b_detected;
   logic [1:0] b_match_count;
   state_t     b_dbg_state;

   param_moore_detector #(.PAT_LEN(PL), .DEFAULT_PAT(4'b1011), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
      .detected(detected), .match_count(match_count), .o_dbg_state(dbg_state)
   );

   param_moore_detector #(.PAT_LEN(2), .DEFAULT_PAT(2'b11), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_bit(b_in_bit),
      .cfg_load(b_cfg_load), .cfg_pattern(b_cfg_pattern), .cfg_overlap(b_cfg_overlap),
      .detected(b_detected), .match_count(b_match_count), .o_dbg_state(b_dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // driver tasks: apply inputs, clock once, sample 1 time unit after the edge
   task automatic drive(input logic ld, input logic [PL-1:0] pat, input logic ov,
                        input logic v, input logic b);
      cfg_load    = ld;
      cfg_pattern = pat;
      cfg_overlap = ov;
      in_valid    = v;
      in_bit      = b;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_b(input logic ld, input logic [1:0] pat, input logic ov,
                          input logic v, input logic b);
      b_cfg_load    = ld;
      b_cfg_pattern = pat;
      b_cfg_overlap = ov;
      b_in_valid    = v;
      b_in_bit      = b;
      @(posedge clk);
      #1;
   endtask

   // vector table
   typedef struct {
      logic          ld;
      logic [PL-1:0] pat;
      logic          ov;
      logic          v;
      logic          b;
      logic          det;
      logic [CW-1:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic ld, input logic [PL-1:0] pat, input logic ov,
                               input logic v, input logic b, input logic det,
                               input logic [CW-1:0] cnt);
      vec_t t;
      t.ld = ld; t.pat = pat; t.ov = ov; t.v = v; t.b = b; t.det = det; t.cnt = cnt;
      vecs.push_back(t);
   endfunction

   // reference model: queue of bits received since the last restart
   logic        m_q[$];
   logic [PL-1:0] m_pat;
   logic        m_ov;
   logic        m_det;
   int          m_cnt;

   function automatic void model_step(input logic ld, input logic [PL-1:0] pat,
                                      input logic ov, input logic v, input logic b);
      bit hit;
      if (ld) begin
         m_q.delete();
         m_pat = pat;
         m_ov  = ov;
         m_det = 1'b0;
         m_cnt = 0;
      end else if (v) begin
         m_q.push_back(b);
         if (m_q.size() > PL) void'(m_q.pop_front());
         hit = (m_q.size() == PL);
         for (int i = 0; i < PL; i++)
            if (hit && (m_q[i] != m_pat[PL-1-i])) hit = 0;
         m_det = hit;
         if (hit) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (!m_ov) m_q.delete();
         end
      end
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       b_det_exp [6];
      logic [1:0] b_cnt_exp [6];
      logic [7:0] rst_stream;

      rst = 1'b1;
      in_valid = 0; in_bit = 0; cfg_load = 0; cfg_pattern = '0; cfg_overlap = 0;
      b_in_valid = 0; b_in_bit = 0; b_cfg_load = 0; b_cfg_pattern = '0; b_cfg_overlap = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset detected", detected, 0);
      check("reset match_count", match_count, 0);
      check("reset state", dbg_state, IDLE);
      rst = 1'b0;

      // default 1011, overlap: 1,0,1,1,0,1,1
      add(0, 4'h0, 0, 1, 1, 0, 0);
      add(0, 4'h0, 0, 1, 0, 0, 0);
      add(0, 4'h0, 0, 1, 1, 0, 0);
      add(0, 4'h0, 0, 1, 1, 1, 1);
      add(0, 4'h0, 0, 1, 0, 0, 1);
      add(0, 4'h0, 0, 1, 1, 0, 1);
      add(0, 4'h0, 0, 1, 1, 1, 2);
      // 1011 non-overlap: same stream
      add(1, 4'b1011, 0, 0, 0, 0, 0);
      add(0, 4'h0, 0, 1, 1, 0, 0);
      add(0, 4'h0, 0, 1, 0, 0, 0);
      add(0, 4'h0, 0, 1, 1, 0, 0);
      add(0, 4'h0, 0, 1, 1, 1, 1);
      add(0, 4'h0, 0, 1, 0, 0, 1);
      add(0, 4'h0, 0, 1, 1, 0, 1);
      add(0, 4'h0, 0, 1, 1, 0, 1);
      // gaps: 1,0,1, three idle, 1, two idle (in_bit=1 while idle)
      add(1, 4'b1011, 1, 0, 0, 0, 0);
      add(0, 4'h0, 0, 1, 1, 0, 0);
      add(0, 4'h0, 0, 1, 0, 0, 0);
      add(0, 4'h0, 0, 1, 1, 0, 0);
      add(0, 4'h0, 0, 0, 1, 0, 0);
      add(0, 4'h0, 0, 0, 1, 0, 0);
      add(0, 4'h0, 0, 0, 1, 0, 0);
      add(0, 4'h0, 0, 1, 1, 1, 1);
      add(0, 4'h0, 0, 0, 1, 1, 1);
      add(0, 4'h0, 0, 0, 0, 1, 1);
      // all-zeros pattern, overlap
      add(1, 4'b0000, 1, 0, 0, 0, 0);
      add(0, 4'h0, 0, 1, 0, 0, 0);
      add(0, 4'h0, 0, 1, 0, 0, 0);
      add(0, 4'h0, 0, 1, 0, 0, 0);
      add(0, 4'h0, 0, 1, 0, 1, 1);
      add(0, 4'h0, 0, 1, 0, 1, 2);
      // cfg_load with a valid 0 while in MATCH: that bit is dropped
      add(1, 4'b0000, 1, 1, 0, 0, 0);
      add(0, 4'h0, 0, 1, 0, 0, 0);
      add(0, 4'h0, 0, 1, 0, 0, 0);
      add(0, 4'h0, 0, 1, 0, 0, 0);
      add(0, 4'h0, 0, 1, 0, 1, 1);

      foreach (vecs[i]) begin
         drive(vecs[i].ld, vecs[i].pat, vecs[i].ov, vecs[i].v, vecs[i].b);
         check($sformatf("vec%0d detected", i), detected, vecs[i].det);
         check($sformatf("vec%0d match_count", i), match_count, vecs[i].cnt);
      end

      // asynchronous reset mid-stream, checked before any clock edge
      #2;
      rst = 1'b1;
      #1;
      check("async rst detected", detected, 0);
      check("async rst match_count", match_count, 0);
      check("async rst state", dbg_state, IDLE);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rst_stream = 8'b0000_1011;
      for (int i = 0; i < 8; i++) begin
         drive(0, 4'h0, 0, 1, rst_stream[7-i]);
         check($sformatf("post-rst bit%0d detected", i), detected, (i == 7));
         check($sformatf("post-rst bit%0d match_count", i), match_count, (i == 7) ? 1 : 0);
      end
      drive(0, 4'h0, 0, 0, 0);

      // PAT_LEN=2, CNT_W=2: six 1s, counter saturates at 3
      b_det_exp = '{0, 1, 1, 1, 1, 1};
      b_cnt_exp = '{0, 1, 2, 3, 3, 3};
      drive_b(1, 2'b11, 1, 0, 0);
      check("b load detected", b_detected, 0);
      check("b load match_count", b_match_count, 0);
      for (int i = 0; i < 6; i++) begin
         drive_b(0, 2'b00, 0, 1, 1);
         check($sformatf("b bit%0d detected", i), b_detected, b_det_exp[i]);
         check($sformatf("b bit%0d match_count", i), b_match_count, b_cnt_exp[i]);
      end
      drive_b(0, 2'b00, 0, 0, 0);

      // randomized stimulus against the queue model
      for (int i = 0; i < 600; i++) begin
         logic          ld, ov, v, b;
         logic [PL-1:0] pat;
         ld  = (i == 0) || ($urandom_range(0, 49) == 0);
         pat = PL'($urandom_range(0, (1 << PL) - 1));
         ov  = 1'($urandom_range(0, 1));
         v   = ($urandom_range(0, 3) != 0);
         b   = 1'($urandom_range(0, 1));
         model_step(ld, pat, ov, v, b);
         drive(ld, pat, ov, v, b);
         check($sformatf("rand%0d detected", i), detected, m_det);
         check($sformatf("rand%0d match_count", i), match_count, m_cnt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
